// File: rtl/csdf_phase_scheduler.sv
// Firing controller for a cyclo-static dataflow actor: round-robin channel grant,
// per-channel phase counters, and a FIRE/EXEC/EMIT handshake with the datapath.
module csdf_phase_scheduler #(
  parameter int FLUX   = 2,
  parameter int PORTS  = 2,
  parameter int NUM_OP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [FLUX*PORTS-1:0]     empty_i,
  input  logic [FLUX-1:0]           full_i,
  output logic [FLUX*PORTS-1:0]     read_o,
  output logic                      fire_o,
  output logic [$clog2(NUM_OP)-1:0] op_sel_o,
  output logic [$clog2(FLUX)-1:0]   ch_sel_o,
  input  logic                      done_i,
  output logic                      write_o,
  output logic                      busy_o
);

  localparam int CHW = $clog2(FLUX);
  localparam int OPW = $clog2(NUM_OP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_EXEC,
    S_EMIT
  } state_e;

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] phase_q [FLUX];

  logic [FLUX-1:0] elig;
  logic [CHW-1:0]  cand;
  logic [CHW-1:0]  grant_ch;
  logic            grant_vld;
  logic            emit_go;

  function automatic logic [CHW-1:0] ch_inc(input logic [CHW-1:0] v);
    return (int'(v) == FLUX - 1) ? '0 : v + CHW'(1);
  endfunction

  function automatic logic [OPW-1:0] phase_inc(input logic [OPW-1:0] v);
    return (int'(v) == NUM_OP - 1) ? '0 : v + OPW'(1);
  endfunction

  // A channel can fire only if every input port holds a token and its output has room.
  always_comb begin : eligibility
    for (int f = 0; f < FLUX; f++) begin
      elig[f] = !full_i[f];
      for (int p = 0; p < PORTS; p++) begin
        if (empty_i[p*FLUX+f]) elig[f] = 1'b0;
      end
    end
  end

  always_comb begin : arbiter
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = rr_q;
    for (int i = 0; i < FLUX; i++) begin
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
      cand = ch_inc(cand);
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    ch_d    = ch_q;
    op_d    = op_q;
    rr_d    = rr_q;
    emit_go = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_i && grant_vld) begin
          state_d = S_FIRE;
          ch_d    = grant_ch;
          op_d    = phase_q[grant_ch];
        end
      end
      S_FIRE: state_d = S_EXEC;
      S_EXEC: if (done_i) state_d = S_EMIT;
      S_EMIT: begin
        // Output backpressure is honoured live here; the push happens in the cycle room appears.
        if (!full_i[ch_q]) begin
          emit_go = 1'b1;
          rr_d    = ch_inc(ch_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      op_q    <= '0;
      rr_q    <= '0;
      // NOTE: the phase array is control state, not a data RAM, so it must clear on reset like any other flop.
      for (int f = 0; f < FLUX; f++) phase_q[f] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q <= state_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      rr_q    <= rr_d;
      if (emit_go) phase_q[ch_q] <= phase_inc(phase_q[ch_q]);
    end
  end

  always_comb begin : read_decode
    read_o = '0;
    for (int f = 0; f < FLUX; f++) begin
      for (int p = 0; p < PORTS; p++) begin
        read_o[p*FLUX+f] = (state_q == S_FIRE) && (int'(ch_q) == f);
      end
    end
  end

  assign fire_o   = (state_q == S_FIRE);
  assign write_o  = emit_go;
  assign busy_o   = (state_q != S_IDLE);
  assign ch_sel_o = ch_q;
  assign op_sel_o = op_q;

endmodule
